spi_target: RTL and testbench

- SPI mode-0 target (slave) byte engine. It is the far-end counterpart of the spi2 master.
- Lets an external SPI master (host MCU or test jig on the SD/MP3 header) exchange bytes with the FPGA's Z80 port logic.
- SPI pins are oversampled in the clk domain. Received bytes are presented with a valid/read handshake; transmit bytes come from a one-entry buffer.

---
 rtl/spi_target.sv | 149 ++++++++++++++
 tb/tb_spi_target.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI mode-0 target byte engine: oversampled pins, rx valid/read handshake, one-entry tx buffer.
// Optional sticky overrun flag enabled by defining SPI_TARGET_OVR_EN.
module spi_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scs_n,
    input  logic       sck,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_full,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_rd,
    output logic       busy,
    output logic       rx_ovr
);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] cs_sy, sck_sy, sdi_sy;
    logic       cs_d, sck_d;
    logic       cs_s, sck_s, sdi_s;
    logic       cs_fall, cs_rise, sck_rise, sck_fall;
    state_t     state, state_nx;
    logic       start, stop, rise_en, fall_en, xfer;
    logic [7:0] tx_buf, txsh, rxsh, tx_next;
    logic [2:0] bitcnt;
    logic       byte_cmp, byte_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sy  <= '1;
            sck_sy <= '0;
            sdi_sy <= '1;
            cs_d   <= 1'b1;
            sck_d  <= 1'b0;
        end else begin
            cs_sy  <= {cs_sy[SYNC_STAGES-2:0], scs_n};
            sck_sy <= {sck_sy[SYNC_STAGES-2:0], sck};
            sdi_sy <= {sdi_sy[SYNC_STAGES-2:0], sdi};
            cs_d   <= cs_sy[SYNC_STAGES-1];
            sck_d  <= sck_sy[SYNC_STAGES-1];
        end
    end

    assign cs_s     = cs_sy[SYNC_STAGES-1];
    assign sck_s    = sck_sy[SYNC_STAGES-1];
    assign sdi_s    = sdi_sy[SYNC_STAGES-1];
    assign cs_fall  = cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_rise = ~sck_d & sck_s;
    assign sck_fall = sck_d & ~sck_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // A deselect in the same cycle as an sck edge suppresses that edge.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        stop     = 1'b0;
        rise_en  = 1'b0;
        fall_en  = 1'b0;
        case (state)
            IDLE: if (cs_fall) begin
                state_nx = SHIFT;
                start    = 1'b1;
            end
            SHIFT: if (cs_rise) begin
                state_nx = IDLE;
                stop     = 1'b1;
            end else begin
                rise_en  = sck_rise;
                fall_en  = sck_fall;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign xfer    = start | (fall_en & byte_done);
    assign tx_next = tx_full ? tx_buf : 8'hFF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_buf    <= 8'hFF;
            tx_full   <= 1'b0;
            txsh      <= 8'hFF;
            rxsh      <= 8'hFF;
            bitcnt    <= 3'd0;
            byte_cmp  <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            byte_cmp <= 1'b0;
            // A load racing a transfer lands in the buffer after the old byte moves out.
            if (tx_load) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end else if (xfer) begin
                tx_full <= 1'b0;
            end
            if (xfer)         txsh <= tx_next;
            else if (fall_en) txsh <= {txsh[6:0], 1'b1};
            if (start || stop) begin
                bitcnt <= 3'd0;
            end else if (rise_en) begin
                rxsh     <= {rxsh[6:0], sdi_s};
                bitcnt   <= bitcnt + 3'd1;
                byte_cmp <= (bitcnt == 3'd7);
            end
            if (start || stop)              byte_done <= 1'b0;
            else if (byte_cmp)              byte_done <= 1'b1;
            else if (fall_en && byte_done)  byte_done <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else if (byte_cmp) begin
            rx_data  <= rxsh;
            rx_valid <= 1'b1;
        end else if (rx_rd) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef SPI_TARGET_OVR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   rx_ovr <= 1'b0;
        else if (byte_cmp && rx_valid && !rx_rd)   rx_ovr <= 1'b1;
        else if (rx_rd)                            rx_ovr <= 1'b0;
    end
`else
    assign rx_ovr = 1'b0;
`endif

    assign busy   = (state == SHIFT);
    assign sdo_oe = (state == SHIFT);
    assign sdo    = (state == SHIFT) ? txsh[7] : 1'b1;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a bench-side SPI master drives bytes, scoreboard queues hold expected MISO/MOSI bytes.
module tb_spi_target;

    logic       clk = 1'b0, rst = 1'b1;
    logic       scs_n = 1'b1, sck = 1'b0, sdi = 1'b1;
    logic       tx_load = 1'b0, rx_rd = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sdo, sdo_oe, tx_full, rx_valid, busy, rx_ovr;
    logic [7:0] rx_data;

    int vectors = 0, miscompares = 0;
    logic [7:0] exp_miso[$], exp_rx[$];
    logic [7:0] got;
    logic       ovr_exp;

    spi_target #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scs_n(scs_n), .sck(sck), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .tx_data(tx_data), .tx_load(tx_load),
        .tx_full(tx_full), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_rd(rx_rd), .busy(busy), .rx_ovr(rx_ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    task automatic pulse_rd();
        rx_rd = 1'b1;
        tick(1);
        rx_rd = 1'b0;
    endtask

    task automatic cs_lo();
        scs_n = 1'b0;
        tick(4);
    endtask

    task automatic cs_hi();
        tick(4);
        scs_n = 1'b1;
        tick(4);
    endtask

    // Mode-0 master, sck period 16 clk; MISO sampled at each rising pin edge.
    task automatic xfer_byte(input logic [7:0] mosi, input int nbits, input bit chk_lat,
                             output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            sdi = mosi[i];
            tick(8);
            sck = 1'b1;
            miso[i] = sdo;
            if (chk_lat && i == 0) begin
                tick(3);
                chk("rx_valid_lat_early", {7'd0, rx_valid}, 8'd0);
                tick(1);
                chk("rx_valid_lat_on", {7'd0, rx_valid}, 8'd1);
                tick(4);
            end else begin
                tick(8);
            end
            sck = 1'b0;
        end
    endtask

    task automatic wait_rx();
        int n = 0;
        while (!rx_valid && n < 20) begin
            tick(1);
            n++;
        end
        chk("rx_valid_seen", {7'd0, rx_valid}, 8'd1);
        chk("rx_data", rx_data, exp_rx.pop_front());
    endtask

    task automatic do_byte(input logic [7:0] mosi, input logic [7:0] miso_exp,
                           input bit lat, input bit rd);
        logic [7:0] m;
        exp_miso.push_back(miso_exp);
        exp_rx.push_back(mosi);
        xfer_byte(mosi, 8, lat, m);
        chk("miso", m, exp_miso.pop_front());
        wait_rx();
        if (rd) begin
            pulse_rd();
            chk("rx_valid_after_rd", {7'd0, rx_valid}, 8'd0);
        end
    endtask

    initial begin
`ifdef SPI_TARGET_OVR_EN
        ovr_exp = 1'b1;
`else
        ovr_exp = 1'b0;
`endif
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_sdo", {7'd0, sdo}, 8'd1);
        chk("rst_sdo_oe", {7'd0, sdo_oe}, 8'd0);
        chk("rst_rx_valid", {7'd0, rx_valid}, 8'd0);
        chk("rst_tx_full", {7'd0, tx_full}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_rx_ovr", {7'd0, rx_ovr}, 8'd0);
        chk("rst_rx_data", rx_data, 8'h00);

        // Single byte with preloaded tx buffer
        pulse_load(8'hA5);
        chk("tx_full_loaded", {7'd0, tx_full}, 8'd1);
        cs_lo();
        chk("tx_full_after_csfall", {7'd0, tx_full}, 8'd0);
        chk("busy_sel", {7'd0, busy}, 8'd1);
        chk("sdo_oe_sel", {7'd0, sdo_oe}, 8'd1);
        do_byte(8'h3C, 8'hA5, 1'b1, 1'b1);
        cs_hi();
        chk("busy_desel", {7'd0, busy}, 8'd0);
        chk("sdo_oe_desel", {7'd0, sdo_oe}, 8'd0);
        chk("sdo_desel", {7'd0, sdo}, 8'd1);

        // Empty buffer, two bytes with reads
        cs_lo();
        do_byte(8'h01, 8'hFF, 1'b1, 1'b1);
        do_byte(8'h80, 8'hFF, 1'b1, 1'b1);
        cs_hi();
        chk("rx_data_final", rx_data, 8'h80);
        pulse_rd();
        chk("rd_when_empty", {7'd0, rx_valid}, 8'd0);

        // Refill during byte 0 feeds byte 1
        pulse_load(8'h11);
        cs_lo();
        pulse_load(8'h22);
        chk("tx_full_refill", {7'd0, tx_full}, 8'd1);
        do_byte(8'h5A, 8'h11, 1'b0, 1'b1);
        tick(4);
        chk("tx_full_after_reload", {7'd0, tx_full}, 8'd0);
        do_byte(8'hC3, 8'h22, 1'b0, 1'b1);
        cs_hi();

        // Partial byte aborted by deselect
        cs_lo();
        xfer_byte(8'hF0, 5, 1'b0, got);
        cs_hi();
        chk("partial_rx_valid", {7'd0, rx_valid}, 8'd0);
        chk("partial_rx_data", rx_data, 8'hC3);
        chk("partial_busy", {7'd0, busy}, 8'd0);
        chk("partial_sdo_oe", {7'd0, sdo_oe}, 8'd0);
        cs_lo();
        do_byte(8'h96, 8'hFF, 1'b0, 1'b1);
        cs_hi();

        // Two bytes with no read in between
        cs_lo();
        do_byte(8'hAA, 8'hFF, 1'b0, 1'b0);
        do_byte(8'h55, 8'hFF, 1'b0, 1'b0);
        cs_hi();
        chk("ovr_rx_data", rx_data, 8'h55);
        chk("ovr_flag", {7'd0, rx_ovr}, {7'd0, ovr_exp});
        chk("ovr_rx_valid", {7'd0, rx_valid}, 8'd1);
        pulse_rd();
        chk("ovr_cleared", {7'd0, rx_ovr}, 8'd0);
        chk("ovr_rx_valid_cleared", {7'd0, rx_valid}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
